ir_byte_reader: RTL and testbench
=================================

Name: ir_byte_reader

Overview:
- Read-side counterpart of the 16-bit IR-style register that is loaded one byte at a time through an 8-bit input with an LH half-select.
- Accepts 16-bit words over a valid/ready handshake and unloads each word onto an 8-bit bus as two byte beats.
- Each beat carries an LH tag with the same meaning as the load side: 0 = low byte [7:0], 1 = high byte [15:8].
- Holds one active word plus one pending word, so back-to-back words stream with no bubble.

Parameters:
- HI_FIRST, 0: 0 sends the low byte then the high byte; 1 sends the high byte then the low byte.
- CNT_W, 8: width of the words_sent counter.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- word_in, input, 16: word to unload.
- word_valid, input, 1: word_in is valid.
- word_ready, output, 1: block can accept a word this cycle.
- byte_out, output, 8: current byte beat.
- byte_lh, output, 1: half tag of byte_out (0 = low, 1 = high).
- byte_valid, output, 1: byte_out/byte_lh are valid.
- byte_ready, input, 1: downstream accepts the beat this cycle.
- flush, input, 1: synchronous abort of all buffered data.
- busy, output, 1: active word or pending word held.
- words_sent, output, CNT_W: count of fully unloaded words.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE; active and pending registers cleared; pending_valid = 0.
  - byte_out = 0, byte_lh = 0, byte_valid = 0, busy = 0, words_sent = 0.
  - word_ready = 0 while rst_n is low. Reset mid-word discards both words; nothing further is emitted.
- word_ready = rst_n & ~pending_valid & ~flush (combinational). Accept = word_valid & word_ready.
- FSM states:
  - IDLE: byte_valid = 0. On accept, word_in goes to the active register; next state FIRST.
  - FIRST: byte_valid = 1; drives the first half (per HI_FIRST) and its LH tag. On byte_valid & byte_ready, next state SECOND.
  - SECOND: byte_valid = 1; drives the other half and its tag. On beat transfer, words_sent increments and:
    - If pending_valid: pending moves to active, pending_valid clears, next state FIRST.
    - Else if accept in the same cycle: word_in goes directly to active, next state FIRST.
    - Else: next state IDLE.
- Accept while in FIRST or SECOND: word goes to pending (except the SECOND-completion case above); pending_valid sets.
- Latency: a word accepted in IDLE at edge N gives byte_valid = 1 on the first beat after edge N. Minimum 2 cycles per word; zero bubbles with a continuous word stream and byte_ready held high.
- Stability: while byte_valid & ~byte_ready, byte_out, byte_lh and the state hold unchanged.
- byte_out and byte_lh are registered, or decoded from registered state only; no combinational path from byte_ready to byte_out.
- busy = (state != IDLE) | pending_valid.
- words_sent wraps from 2^CNT_W-1 to 0 and is not cleared by flush.
- flush (sampled at the clock edge):
  - Next state IDLE; pending_valid = 0; byte_valid = 0 the next cycle.
  - No word accepted that cycle.
  - A beat that transfers in the flush cycle is consumed, but words_sent increments only if that beat was SECOND.
- Simultaneous accept and pending move in one cycle cannot occur: word_ready is low whenever pending_valid = 1.

Test Plan:
- Reset, then word 16'hAA05 with HI_FIRST = 0 and byte_ready = 1:
  - beat 1: byte_out = 8'h05, byte_lh = 0;
  - beat 2: byte_out = 8'hAA, byte_lh = 1;
  - words_sent = 1, then back to IDLE with busy = 0.
- HI_FIRST = 1, words 16'h1234 and 16'h5678 offered back-to-back with byte_ready = 1:
  - beats 12/1, 34/0, 56/1, 78/0 on four consecutive cycles, no bubble;
  - word_ready low exactly while pending is full.
- Backpressure: word 16'hBEEF, byte_ready low for 3 cycles in FIRST:
  - byte_out = 8'hEF, byte_lh = 0 held for all 3 cycles;
  - on release, 8'hBE/1 follows;
  - a third word offered while active and pending are full sees word_ready = 0.
- flush asserted in SECOND with a pending word: byte_valid = 0 next cycle, busy = 0, words_sent unchanged, the pending word is never emitted.
- rst_n pulsed low mid-FIRST (asynchronous, between edges): byte_valid, busy and words_sent drop to 0 immediately; word_ready = 1 after release.
- 256 words streamed with CNT_W = 8: words_sent wraps to 0 after the 256th word.

Source files
------------

// File: rtl/ir_byte_reader.sv
// ---------------------------------------------------------------------------
// ir_byte_reader
//
// Read-side counterpart of a 16-bit register that is loaded one byte at a
// time. The block takes 16-bit words over a valid/ready handshake and
// unloads each one onto an 8-bit bus as two byte beats. Each beat carries an
// LH tag: 0 = low byte [7:0], 1 = high byte [15:8]. There is one active word
// and one pending word, so a continuous word stream unloads with no bubble.
//
// Parameters:
//   HI_FIRST   - 0: low byte first, then high byte; 1: high byte first.
//   CNT_W      - width of the words_sent counter (wraps).
//
// Ports:
//   clk        - system clock, rising edge.
//   rst_n      - asynchronous active-low reset.
//   word_in    - word to unload.
//   word_valid - word_in is valid.
//   word_ready - block can accept a word this cycle.
//   byte_out   - current byte beat.
//   byte_lh    - half tag of byte_out (0 = low, 1 = high).
//   byte_valid - byte_out/byte_lh are valid.
//   byte_ready - downstream accepts the beat this cycle.
//   flush      - synchronous abort of all buffered data.
//   busy       - active word or pending word held.
//   words_sent - count of fully unloaded words.
// ---------------------------------------------------------------------------
module ir_byte_reader #(
  parameter logic HI_FIRST = 1'b0,
  parameter int   CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic [7:0]       byte_out,
  output logic             byte_lh,
  output logic             byte_valid,
  input  logic             byte_ready,
  input  logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2
  } state_t;

  state_t           r_state, w_state_next;
  logic [15:0]      r_active, w_active_next;
  logic [15:0]      r_pending, w_pending_next;
  logic             r_pending_valid, w_pending_valid_next;
  logic [CNT_W-1:0] r_words_sent, w_words_sent_next;

  logic w_accept;
  logic w_xfer;

  // Ready depends on flush so that no word is taken in a flush cycle, and on
  // the pending slot so that an accept can never coincide with a pending move.
  assign word_ready = rst_n & ~r_pending_valid & ~flush;
  assign w_accept   = word_valid & word_ready;
  assign w_xfer     = byte_valid & byte_ready;

  assign busy       = (r_state != S_IDLE) | r_pending_valid;
  assign words_sent = r_words_sent;

  // Beat outputs are decoded from registered state only, so byte_ready has
  // no combinational path to byte_out/byte_lh.
  always_comb begin
    byte_valid = (r_state != S_IDLE);
    byte_out   = 8'h00;
    byte_lh    = 1'b0;
    case (r_state)
      S_FIRST: begin
        byte_lh  = HI_FIRST;
        byte_out = HI_FIRST ? r_active[15:8] : r_active[7:0];
      end
      S_SECOND: begin
        byte_lh  = ~HI_FIRST;
        byte_out = HI_FIRST ? r_active[7:0] : r_active[15:8];
      end
      default: begin
        byte_lh  = 1'b0;
        byte_out = 8'h00;
      end
    endcase
  end

  always_comb begin
    w_state_next         = r_state;
    w_active_next        = r_active;
    w_pending_next       = r_pending;
    w_pending_valid_next = r_pending_valid;
    w_words_sent_next    = r_words_sent;

    if (flush) begin
      // A beat moving in the flush cycle is consumed; only a completed word
      // (second beat) counts.
      w_state_next         = S_IDLE;
      w_pending_valid_next = 1'b0;
      if ((r_state == S_SECOND) && w_xfer) begin
        w_words_sent_next = r_words_sent + 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_active_next = word_in;
            w_state_next  = S_FIRST;
          end
        end

        S_FIRST: begin
          if (w_xfer) begin
            w_state_next = S_SECOND;
          end
          if (w_accept) begin
            w_pending_next       = word_in;
            w_pending_valid_next = 1'b1;
          end
        end

        S_SECOND: begin
          if (w_xfer) begin
            w_words_sent_next = r_words_sent + 1'b1;
            if (r_pending_valid) begin
              w_active_next        = r_pending;
              w_pending_valid_next = 1'b0;
              w_state_next         = S_FIRST;
            end else if (w_accept) begin
              // Word arrives exactly as the active one finishes: bypass the
              // pending slot to keep the stream bubble-free.
              w_active_next = word_in;
              w_state_next  = S_FIRST;
            end else begin
              w_state_next = S_IDLE;
            end
          end else if (w_accept) begin
            w_pending_next       = word_in;
            w_pending_valid_next = 1'b1;
          end
        end

        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_active        <= 16'h0000;
      r_pending       <= 16'h0000;
      r_pending_valid <= 1'b0;
      r_words_sent    <= '0;
    end else begin
      r_state         <= w_state_next;
      r_active        <= w_active_next;
      r_pending       <= w_pending_next;
      r_pending_valid <= w_pending_valid_next;
      r_words_sent    <= w_words_sent_next;
    end
  end

endmodule

// File: tb/tb_ir_byte_reader.sv
// ---------------------------------------------------------------------------
// tb_ir_byte_reader
//
// Two instances (low-first and high-first) share one stimulus. A scoreboard
// queue holds accepted words; each falling edge compares both instances'
// beats, valid, busy, word_ready and words_sent against it. Hand-written
// sequences cover the table of single words, back-to-back streaming,
// backpressure, flush, asynchronous reset and counter wrap.
// ---------------------------------------------------------------------------
module tb_ir_byte_reader;

  logic        clk;
  logic        rst_n;
  logic [15:0] word_in;
  logic        word_valid;
  logic        byte_ready;
  logic        flush;

  logic        wr0, wr1;
  logic [7:0]  bo0, bo1;
  logic        lh0, lh1;
  logic        bv0, bv1;
  logic        busy0, busy1;
  logic [7:0]  ws0, ws1;

  int n_cmp = 0;
  int n_err = 0;

  ir_byte_reader #(.HI_FIRST(1'b0), .CNT_W(8)) u_lo_first (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(wr0), .byte_out(bo0), .byte_lh(lh0), .byte_valid(bv0),
    .byte_ready(byte_ready), .flush(flush), .busy(busy0), .words_sent(ws0)
  );

  ir_byte_reader #(.HI_FIRST(1'b1), .CNT_W(8)) u_hi_first (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(wr1), .byte_out(bo1), .byte_lh(lh1), .byte_valid(bv1),
    .byte_ready(byte_ready), .flush(flush), .busy(busy1), .words_sent(ws1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------ scoreboard
  logic [15:0] sb_q[$];
  int          sb_bi;     // 0: next beat is the first of the head word
  logic [7:0]  exp_ws;
  bit          sb_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q.delete();
      sb_bi  = 0;
      exp_ws = 8'h00;
    end else begin
      sb_acc = word_valid && !flush && (sb_q.size() < 2);
      if ((sb_q.size() > 0) && byte_ready) begin
        if (sb_bi == 1) begin
          void'(sb_q.pop_front());
          sb_bi  = 0;
          exp_ws = exp_ws + 8'd1;
        end else begin
          sb_bi = 1;
        end
      end
      if (flush) begin
        sb_q.delete();
        sb_bi = 0;
      end
      if (sb_acc) begin
        sb_q.push_back(word_in);
        $display("word accepted %04h (queued %0d)", word_in, sb_q.size());
      end
    end
  end

  logic        exp_v, exp_rdy;
  logic [15:0] exp_w;
  logic [8:0]  exp_b0, exp_b1;

  always @(negedge clk) begin
    exp_v   = (sb_q.size() != 0);
    exp_rdy = rst_n && !flush && (sb_q.size() < 2);
    chk("sb_valid0", bv0, exp_v);
    chk("sb_valid1", bv1, exp_v);
    chk("sb_busy0", busy0, exp_v);
    chk("sb_busy1", busy1, exp_v);
    chk("sb_ready0", wr0, exp_rdy);
    chk("sb_ready1", wr1, exp_rdy);
    chk("sb_ws0", ws0, exp_ws);
    chk("sb_ws1", ws1, exp_ws);
    if (exp_v) begin
      exp_w  = sb_q[0];
      exp_b0 = (sb_bi == 1) ? {exp_w[15:8], 1'b1} : {exp_w[7:0], 1'b0};
      exp_b1 = (sb_bi == 1) ? {exp_w[7:0], 1'b0} : {exp_w[15:8], 1'b1};
      chk("sb_beat0", {bo0, lh0}, exp_b0);
      chk("sb_beat1", {bo1, lh1}, exp_b1);
    end
  end

  // ------------------------------------------------------------------ stimulus
  typedef struct packed {
    logic [15:0] word;
    logic [7:0]  lo;
    logic [7:0]  hi;
  } vec_t;

  vec_t tbl[5];

  task automatic send_word(input logic [15:0] w);
    int n;
    n = 0;
    word_in    = w;
    word_valid = 1'b1;
    #1;
    while (!(wr0 && wr1) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: word_ready low for %0d cycles, required high", n);
    end
    @(posedge clk);
    #1;
    word_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] ws_before;

    tbl[0] = '{word: 16'hAA05, lo: 8'h05, hi: 8'hAA};
    tbl[1] = '{word: 16'h1234, lo: 8'h34, hi: 8'h12};
    tbl[2] = '{word: 16'h00FF, lo: 8'hFF, hi: 8'h00};
    tbl[3] = '{word: 16'hFF00, lo: 8'h00, hi: 8'hFF};
    tbl[4] = '{word: 16'h8001, lo: 8'h01, hi: 8'h80};

    rst_n = 1'b0; word_in = 16'h0; word_valid = 1'b0; byte_ready = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid0", bv0, 0);
    chk("rst_valid1", bv1, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_ws0", ws0, 0);
    chk("rst_byte0", {bo0, lh0}, 0);
    chk("rst_ready0", wr0, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready0", wr0, 1);

    // Single words, table-driven, both byte orders.
    for (int i = 0; i < 5; i++) begin
      word_in = tbl[i].word; word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      chk("tbl_first0", {bo0, lh0, bv0}, {tbl[i].lo, 1'b0, 1'b1});
      chk("tbl_first1", {bo1, lh1, bv1}, {tbl[i].hi, 1'b1, 1'b1});
      tick();
      chk("tbl_second0", {bo0, lh0, bv0}, {tbl[i].hi, 1'b1, 1'b1});
      chk("tbl_second1", {bo1, lh1, bv1}, {tbl[i].lo, 1'b0, 1'b1});
      tick();
      chk("tbl_ws0", ws0, i + 1);
      chk("tbl_idle0", {bv0, busy0}, 2'b00);
      chk("tbl_idle1", {bv1, busy1}, 2'b00);
    end

    // Back-to-back words, no bubble, high-first view.
    word_in = 16'h1234; word_valid = 1'b1;
    tick();
    chk("b2b_12", {bo1, lh1}, {8'h12, 1'b1});
    word_in = 16'h5678;
    #1;
    chk("b2b_ready_open", wr1, 1);
    tick();
    word_valid = 1'b0;
    chk("b2b_34", {bo1, lh1}, {8'h34, 1'b0});
    chk("b2b_ready_full", wr1, 0);
    tick();
    chk("b2b_56", {bo1, lh1, bv1}, {8'h56, 1'b1, 1'b1});
    chk("b2b_ready_free", wr1, 1);
    tick();
    chk("b2b_78", {bo1, lh1, bv1}, {8'h78, 1'b0, 1'b1});
    tick();
    chk("b2b_idle", bv1, 0);
    chk("b2b_ws", ws1, 7);

    // Backpressure in FIRST, low-first view.
    byte_ready = 1'b0;
    word_in = 16'hBEEF; word_valid = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold", {bo0, lh0, bv0}, {8'hEF, 1'b0, 1'b1});
      if (k == 0) begin
        word_in = 16'h1111;
      end else if (k == 1) begin
        word_in = 16'h2222;
        #1;
        chk("bp_ready_full", wr0, 0);
      end else begin
        word_valid = 1'b0;
      end
      tick();
    end
    chk("bp_hold_last", {bo0, lh0}, {8'hEF, 1'b0});
    byte_ready = 1'b1;
    tick();
    chk("bp_BE", {bo0, lh0}, {8'hBE, 1'b1});
    tick();
    chk("bp_11_lo", {bo0, lh0}, {8'h11, 1'b0});
    tick();
    chk("bp_11_hi", {bo0, lh0}, {8'h11, 1'b1});
    tick();
    chk("bp_idle", bv0, 0);
    chk("bp_ws", ws0, 9);

    // Flush in SECOND with a pending word.
    word_in = 16'h3333; word_valid = 1'b1;
    tick();
    word_in = 16'h4444;
    tick();
    word_valid = 1'b0;
    chk("fl_second", {bo0, lh0}, {8'h33, 1'b1});
    ws_before = ws0;
    byte_ready = 1'b0; flush = 1'b1;
    #1;
    chk("fl_ready", wr0, 0);
    chk("fl_busy_before", busy0, 1);
    tick();
    flush = 1'b0;
    chk("fl_valid", bv0, 0);
    chk("fl_busy", busy0, 0);
    chk("fl_ws", ws0, 9);
    byte_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("fl_no_pending", bv0, 0);
    end

    // Asynchronous reset mid-FIRST.
    byte_ready = 1'b0;
    word_in = 16'h7777; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    chk("ar_first", bv0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {bv0, bv1}, 2'b00);
    chk("ar_busy", {busy0, busy1}, 2'b00);
    chk("ar_ws", ws0, 0);
    chk("ar_ready", wr0, 0);
    #2 rst_n = 1'b1;
    byte_ready = 1'b1;
    tick();
    chk("ar_ready_after", wr0, 1);
    chk("ar_idle", bv0, 0);

    // 256 words: counter wraps to 0.
    for (int i = 0; i < 256; i++) begin
      send_word(16'($urandom));
    end
    n = 0;
    while ((busy0 || busy1) && n < 20) begin
      tick();
      n++;
    end
    chk("wrap_drained", {busy0, busy1}, 2'b00);
    chk("wrap_ws0", ws0, 0);
    chk("wrap_ws1", ws1, 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
